// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder unit: restoring division, one quotient bit per cycle,
// with RISC-V divide-by-zero and signed-overflow results produced without iterating.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [XLEN:0]   rem_part;
    logic [XLEN-1:0] quo_shift;
    logic [XLEN-1:0] divisor_mag;
    logic [CW-1:0]   count;
    logic            is_rem;
    logic            neg_quo;
    logic            neg_rem;

    // op[0] = unsigned variant, op[1] = remainder variant
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic            issue;

    assign sign_a   = dividend[XLEN-1] & ~op[0];
    assign sign_b   = divisor[XLEN-1] & ~op[0];
    assign mag_a    = sign_a ? -dividend : dividend;
    assign mag_b    = sign_b ? -divisor : divisor;
    assign div_zero = (divisor == '0);
    assign overflow = ~op[0] && (dividend == MIN_NEG) && (divisor == '1);
    assign special  = div_zero || overflow;
    assign issue    = (state == IDLE) && start && !flush;

    // A set top bit in the partial remainder would mean the shifted value exceeds any divisor.
    logic [XLEN:0]   rem_shift;
    logic            take;
    logic [XLEN:0]   rem_sub;

    assign rem_shift = {rem_part[XLEN-1:0], quo_shift[XLEN-1]};
    assign take      = rem_part[XLEN] || (rem_shift >= {1'b0, divisor_mag});
    assign rem_sub   = rem_shift - {1'b0, divisor_mag};

    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign quo_fixed = neg_quo ? -quo_shift : quo_shift;
    assign rem_fixed = neg_rem ? -rem_part[XLEN-1:0] : rem_part[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    busy       = 1'b1;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == CW'(XLEN - 1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_part    <= '0;
            quo_shift   <= '0;
            divisor_mag <= '0;
            count       <= '0;
            is_rem      <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            result      <= '0;
        end else if (!flush) begin
            if (issue) begin
                is_rem      <= op[1];
                neg_quo     <= sign_a ^ sign_b;
                neg_rem     <= sign_a;
                divisor_mag <= mag_b;
                quo_shift   <= mag_a;
                rem_part    <= '0;
                count       <= '0;
                if (div_zero) begin
                    result <= op[1] ? dividend : '1;
                end else if (overflow) begin
                    result <= op[1] ? '0 : MIN_NEG;
                end
            end else if (state == CALC) begin
                rem_part  <= take ? rem_sub : rem_shift;
                quo_shift <= {quo_shift[XLEN-2:0], take};
                count     <= count + 1'b1;
            end else if (state == FIXUP) begin
                result <= is_rem ? rem_fixed : quo_fixed;
            end
        end
    end

endmodule
